kcpsmx_regfile_arbiter: RTL and testbench
=========================================

// Module: kcpsmx_regfile_arbiter
// PURPOSE
//  Shares the 16-entry KCPSMX register file (1 write port, 2 async read ports) between
//  the pipeline and a debug/host port. Pipeline has absolute priority; debug accesses
//  use idle write/Y-read slots and force a 1-cycle pipeline stall on starvation.
//  Sits between the pipeline writeback/decode stages and kcpsmx_register.
// PARAMETERS
//  STARVE_LIMIT  default 8  PEND cycles without a free slot before a stall is forced (>=1)
// PORTS
//  clk          in   1   system clock, all state on posedge
//  reset        in   1   asynchronous, active-low reset
//  pipe_we      in   1   pipeline writeback enable
//  pipe_w_addr  in   REGISTER_DEPTH  pipeline writeback address
//  pipe_w_data  in   REGISTER_WIDTH  pipeline writeback data
//  pipe_x_addr  in   REGISTER_DEPTH  pipeline X read address (pass-through)
//  pipe_y_addr  in   REGISTER_DEPTH  pipeline Y read address
//  pipe_y_use   in   1   pipeline needs the Y port this cycle
//  pipe_stall   out  1   registered; pipeline holds, must drive pipe_we=0, pipe_y_use=0
//  dbg_req      in   1   debug request; accepted when dbg_req & dbg_ready at posedge
//  dbg_we       in   1   1=write, 0=read (sampled at accept)
//  dbg_addr     in   REGISTER_DEPTH  debug register address (sampled at accept)
//  dbg_wdata    in   REGISTER_WIDTH  debug write data (sampled at accept)
//  dbg_ready    out  1   state==IDLE
//  dbg_ack      out  1   1-cycle completion pulse
//  dbg_rdata    out  REGISTER_WIDTH  read result, valid with dbg_ack, held until next ack
//  rf_we, rf_w_addr, rf_w_data  out  1/DEPTH/WIDTH  to register file write port
//  rf_x_addr, rf_y_addr  out  DEPTH  to register file read ports
//  rf_y_data    in   REGISTER_WIDTH  register file Y read data
// BEHAVIOUR
//  Reset: state IDLE, pipe_stall=0, dbg_ack=0, dbg_rdata=0, starve count=0; rf_* pure pass-through.
//  rf_x_addr=pipe_x_addr always. Write port: pipe_we=1 -> pipeline drives rf_*; else debug if
//   granted. rf_y_addr=pipe_y_addr unless a debug read is granted. All rf_* combinational.
//  Slot free: write -> !pipe_we; read -> !pipe_y_use. Evaluated in PEND and STALL only.
//  FSM (state_t): IDLE -accept-> PEND (latch we/addr/wdata, cnt=0).
//   PEND: slot free -> perform access this cycle, -> ACK. Else cnt++; cnt==STARVE_LIMIT-1 -> STALL.
//   STALL: pipe_stall=1; slot free -> access, -> ACK; pipeline violation (slot busy) -> stay STALL.
//   ACK: dbg_ack=1, -> IDLE. Min accept-to-ack: 2 cycles; max (no violation) STARVE_LIMIT+2.
//  Debug write: rf_we=1 in grant cycle (file writes on negedge of same cycle).
//  Debug read: rf_y_data captured into dbg_rdata at posedge ending the grant cycle.
//  Same-cycle pipe_we & debug write to same addr: pipeline wins; debug write performed later.
//  dbg_req ignored outside IDLE; dbg_req in ACK cycle not accepted until IDLE.
//  Reset mid-operation: access abandoned, no ack, pipe_stall drops asynchronously.
// CONFIGURATION
//  KCPSMX_RF_STARVE_EN defined: starvation counter and STALL state as above.
//  Undefined: no counter, pipe_stall tied 0, PEND waits indefinitely for a free slot.
// STRUCTURE
//  kcpsmx3_inc gains: typedef enum logic [1:0] {RFA_IDLE,RFA_PEND,RFA_STALL,RFA_ACK}
//   rf_arb_state_t; localparam RF_STARVE_LIMIT_DEF=8. Reuses REGISTER_DEPTH/WIDTH.
//  Single module; counter inline, no sub-module. Bench instantiates kcpsmx_register as load.
// TESTING
//  1 Idle pipe, dbg write r5=0xA7 -> rf_we pulse 1 cycle, ack 2 cycles after accept; read r5 -> 0xA7.
//  2 pipe_we every cycle, STARVE_LIMIT=4, dbg write r3=0x11 -> pipe_stall 1 cycle after 4 PEND, r3=0x11.
//  3 pipe_we r2=0x55 and dbg write r2=0x99 same cycle -> r2=0x55 first, then 0x99, ack after.
//  4 pipe_y_use=1 for 2 cycles, dbg read r7 -> no stall, rdata=r7 at ack, pipeline Y addr untouched.
//  5 reset low while in PEND/STALL -> IDLE, no ack, pipe_stall=0, dbg_ready=1 after release.
//  6 KCPSMX_RF_STARVE_EN undefined, pipe_we held 20 cycles -> no stall, ack 2 cycles after pipe_we drops.

Source files
------------

// File: rtl/kcpsmx_regfile_arbiter_pkg.sv
// Shared types and constants for the KCPSMX register-file arbiter.
// Register file geometry: 16 entries (4-bit address) of 8 bits.
package kcpsmx_regfile_arbiter_pkg;

  localparam int REGISTER_DEPTH      = 4;
  localparam int REGISTER_WIDTH      = 8;
  localparam int RF_STARVE_LIMIT_DEF = 8;

  typedef enum logic [1:0] {
    RFA_IDLE,
    RFA_PEND,
    RFA_STALL,
    RFA_ACK
  } rf_arb_state_t;

  // Debug operation captured at accept time.
  typedef struct packed {
    logic                      we;
    logic [REGISTER_DEPTH-1:0] addr;
    logic [REGISTER_WIDTH-1:0] wdata;
  } rf_dbg_op_t;

  // A write needs the write port idle; a read needs the Y read port idle.
  function automatic logic rfa_slot_free(input logic op_we,
                                         input logic pipe_we,
                                         input logic pipe_y_use);
    return op_we ? !pipe_we : !pipe_y_use;
  endfunction

endpackage

// File: rtl/kcpsmx_regfile_arbiter.sv
// Shares the KCPSMX register file write port and Y read port between the pipeline and a debug port.
// Define KCPSMX_RF_STARVE_EN to enable the starvation counter and the one-cycle forced pipe_stall.
module kcpsmx_regfile_arbiter
  import kcpsmx_regfile_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = RF_STARVE_LIMIT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pipe_we,
  input  logic [REGISTER_DEPTH-1:0] pipe_w_addr,
  input  logic [REGISTER_WIDTH-1:0] pipe_w_data,
  input  logic [REGISTER_DEPTH-1:0] pipe_x_addr,
  input  logic [REGISTER_DEPTH-1:0] pipe_y_addr,
  input  logic                      pipe_y_use,
  output logic                      pipe_stall,
  input  logic                      dbg_req,
  input  logic                      dbg_we,
  input  logic [REGISTER_DEPTH-1:0] dbg_addr,
  input  logic [REGISTER_WIDTH-1:0] dbg_wdata,
  output logic                      dbg_ready,
  output logic                      dbg_ack,
  output logic [REGISTER_WIDTH-1:0] dbg_rdata,
  output logic                      rf_we,
  output logic [REGISTER_DEPTH-1:0] rf_w_addr,
  output logic [REGISTER_WIDTH-1:0] rf_w_data,
  output logic [REGISTER_DEPTH-1:0] rf_x_addr,
  output logic [REGISTER_DEPTH-1:0] rf_y_addr,
  input  logic [REGISTER_WIDTH-1:0] rf_y_data
);

  // A starvation limit below one is meaningless; this block marks the illegal range.
  if (STARVE_LIMIT < 1) begin : g_illegal_starve_limit
  end

  rf_arb_state_t state;
  rf_dbg_op_t    op;
  logic          slot_free;
  logic          grant;
  logic          dbg_wr_grant;
  logic          dbg_rd_grant;

`ifdef KCPSMX_RF_STARVE_EN
  localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);

  logic [CW-1:0] starve_cnt;
  logic          stall_reg;

  assign pipe_stall = stall_reg;
`else
  assign pipe_stall = 1'b0;
`endif

  assign slot_free    = rfa_slot_free(op.we, pipe_we, pipe_y_use);
  assign grant        = ((state == RFA_PEND) || (state == RFA_STALL)) && slot_free;
  assign dbg_wr_grant = grant && op.we;
  assign dbg_rd_grant = grant && !op.we;
  assign dbg_ready    = (state == RFA_IDLE);

  // A debug write is only granted when pipe_we is low, so the pipeline always wins the port.
  assign rf_x_addr = pipe_x_addr;
  assign rf_we     = pipe_we || dbg_wr_grant;
  assign rf_w_addr = dbg_wr_grant ? op.addr  : pipe_w_addr;
  assign rf_w_data = dbg_wr_grant ? op.wdata : pipe_w_data;
  assign rf_y_addr = dbg_rd_grant ? op.addr  : pipe_y_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RFA_IDLE;
      op        <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
`ifdef KCPSMX_RF_STARVE_EN
      starve_cnt <= '0;
      stall_reg  <= 1'b0;
`endif
    end else begin
      dbg_ack <= 1'b0;
      case (state)
        RFA_IDLE: begin
          if (dbg_req) begin
            state    <= RFA_PEND;
            op.we    <= dbg_we;
            op.addr  <= dbg_addr;
            op.wdata <= dbg_wdata;
`ifdef KCPSMX_RF_STARVE_EN
            starve_cnt <= '0;
`endif
          end
        end
        RFA_PEND, RFA_STALL: begin
          if (slot_free) begin
            state   <= RFA_ACK;
            dbg_ack <= 1'b1;
            if (!op.we) begin
              dbg_rdata <= rf_y_data;
            end
`ifdef KCPSMX_RF_STARVE_EN
            stall_reg <= 1'b0;
          end else if (state == RFA_PEND) begin
            // STALL persists while the pipeline ignores pipe_stall and keeps the slot busy.
            if (starve_cnt == CNT_LAST) begin
              state     <= RFA_STALL;
              stall_reg <= 1'b1;
            end else begin
              starve_cnt <= starve_cnt + CW'(1);
            end
`endif
          end
        end
        RFA_ACK: begin
          state <= RFA_IDLE;
        end
        default: begin
          state <= RFA_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kcpsmx_regfile_arbiter.sv
// Bench for kcpsmx_regfile_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Honours KCPSMX_RF_STARVE_EN in the same way as the design.
`timescale 1ns/1ps
module tb_kcpsmx_regfile_arbiter;
  import kcpsmx_regfile_arbiter_pkg::*;

  localparam int LIMIT = 4;
  localparam int AW    = REGISTER_DEPTH;
  localparam int DW    = REGISTER_WIDTH;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pipe_we = 1'b0;
  logic [AW-1:0] pipe_w_addr = '0;
  logic [DW-1:0] pipe_w_data = '0;
  logic [AW-1:0] pipe_x_addr = '0;
  logic [AW-1:0] pipe_y_addr = '0;
  logic          pipe_y_use = 1'b0;
  logic          pipe_stall;
  logic          dbg_req = 1'b0;
  logic          dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_ready;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          rf_we;
  logic [AW-1:0] rf_w_addr;
  logic [DW-1:0] rf_w_data;
  logic [AW-1:0] rf_x_addr;
  logic [AW-1:0] rf_y_addr;
  logic [DW-1:0] rf_y_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kcpsmx_regfile_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_w_addr(pipe_w_addr), .pipe_w_data(pipe_w_data),
    .pipe_x_addr(pipe_x_addr), .pipe_y_addr(pipe_y_addr), .pipe_y_use(pipe_y_use),
    .pipe_stall(pipe_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ready(dbg_ready), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .rf_x_addr(rf_x_addr), .rf_y_addr(rf_y_addr), .rf_y_data(rf_y_data)
  );

  // Register file load: writes on the falling edge, asynchronous Y read.
  logic [DW-1:0] rf_mem [16] = '{default: '0};
  always @(negedge clk) if (rf_we) rf_mem[rf_w_addr] <= rf_w_data;
  assign rf_y_data = rf_mem[rf_y_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding debug op, busy-cycle count, ack owed, register contents.
  logic          m_busy = 1'b0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_ack = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  int            m_wait = 0;
  logic [DW-1:0] m_mem [16] = '{default: '0};

  always @(negedge clk) begin : cmp
    logic          e_ready, e_stall, free, grant, e_we;
    logic [AW-1:0] e_wa, e_ya;
    logic [DW-1:0] e_wd;
    if (!reset) begin
      m_busy  = 1'b0;
      m_ack   = 1'b0;
      m_rdata = '0;
      m_wait  = 0;
    end
    e_ready = !m_busy && !m_ack;
`ifdef KCPSMX_RF_STARVE_EN
    e_stall = m_busy && (m_wait >= LIMIT);
`else
    e_stall = 1'b0;
`endif
    free  = m_we ? !pipe_we : !pipe_y_use;
    grant = reset && m_busy && free;
    e_we  = pipe_we || (grant && m_we);
    e_wa  = pipe_we ? pipe_w_addr : m_addr;
    e_wd  = pipe_we ? pipe_w_data : m_wdata;
    e_ya  = (grant && !m_we) ? m_addr : pipe_y_addr;

    check("dbg_ready", dbg_ready, e_ready);
    check("pipe_stall", pipe_stall, e_stall);
    check("dbg_ack", dbg_ack, m_ack);
    check("dbg_rdata", dbg_rdata, m_rdata);
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_w_addr", rf_w_addr, e_wa);
      check("rf_w_data", rf_w_data, e_wd);
    end
    check("rf_x_addr", rf_x_addr, pipe_x_addr);
    check("rf_y_addr", rf_y_addr, e_ya);

    if (e_we) m_mem[e_wa] = e_wd;
    if (reset) begin
      m_ack = grant;
      if (grant && !m_we) m_rdata = m_mem[m_addr];
      if (grant) m_busy = 1'b0;
      else if (m_busy) m_wait++;
      if (e_ready && dbg_req) begin
        m_busy  = 1'b1;
        m_we    = dbg_we;
        m_addr  = dbg_addr;
        m_wdata = dbg_wdata;
        m_wait  = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    while (!dbg_ready && n < 50) begin step(); n++; end
    if (n >= 50) check("dbg_ready_timeout", 32'd0, 32'd1);
    step();
    dbg_req = 1'b0;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    while (!dbg_ack && cyc < 100) begin step(); cyc++; end
    if (!dbg_ack) check("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int level;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", dbg_ready, 1);
    check("rst_stall", pipe_stall, 0);
    check("rst_ack", dbg_ack, 0);
    check("rst_rdata", dbg_rdata, 0);
    reset = 1'b1;
    step();

    // T1: idle pipeline, debug write then read of r5
    dbg_issue(1'b1, 4'd5, 8'hA7);
    check("t1_rf_we", rf_we, 1);
    check("t1_rf_w_addr", rf_w_addr, 5);
    check("t1_rf_w_data", rf_w_data, 8'hA7);
    step();
    check("t1_ack", dbg_ack, 1);
    check("t1_rf_we_off", rf_we, 0);
    step();
    check("t1_ack_pulse", dbg_ack, 0);
    check("t1_mem5", rf_mem[5], 8'hA7);
    dbg_issue(1'b0, 4'd5, 8'h00);
    check("t1_rd_y_addr", rf_y_addr, 5);
    step();
    check("t1_rd_ack", dbg_ack, 1);
    check("t1_rdata", dbg_rdata, 8'hA7);
    step();

    // T3: pipeline and debug both write r2; pipeline first
    dbg_issue(1'b1, 4'd2, 8'h99);
    pipe_we = 1'b1; pipe_w_addr = 4'd2; pipe_w_data = 8'h55;
    #1;
    check("t3_pipe_wins", rf_w_data, 8'h55);
    step();
    check("t3_mem2_pipe", rf_mem[2], 8'h55);
    check("t3_no_ack_yet", dbg_ack, 0);
    pipe_we = 1'b0;
    #1;
    check("t3_dbg_data", rf_w_data, 8'h99);
    step();
    check("t3_ack", dbg_ack, 1);
    check("t3_mem2_dbg", rf_mem[2], 8'h99);
    step();

    // T4: Y port busy for two cycles, debug read of r7
    pipe_we = 1'b1; pipe_w_addr = 4'd7; pipe_w_data = 8'h3C;
    step();
    pipe_we = 1'b0; pipe_y_use = 1'b1; pipe_y_addr = 4'd9;
    dbg_issue(1'b0, 4'd7, 8'h00);
    check("t4_y_pipe_0", rf_y_addr, 9);
    step();
    check("t4_y_pipe_1", rf_y_addr, 9);
    check("t4_no_stall", pipe_stall, 0);
    step();
    pipe_y_use = 1'b0;
    #1;
    check("t4_y_dbg", rf_y_addr, 7);
    step();
    check("t4_ack", dbg_ack, 1);
    check("t4_rdata", dbg_rdata, 8'h3C);
    check("t4_no_stall_ack", pipe_stall, 0);
    step();

`ifdef KCPSMX_RF_STARVE_EN
    // T2: pipeline writes every cycle, forced stall after LIMIT PEND cycles
    pipe_we = 1'b1; pipe_w_addr = 4'd0; pipe_w_data = 8'h01;
    dbg_issue(1'b1, 4'd3, 8'h11);
    n = 0;
    while (!pipe_stall && n < 20) begin step(); n++; end
    check("t2_stall_after", n, LIMIT);
    pipe_we = 1'b0;
    step();
    check("t2_stall_one_cycle", pipe_stall, 0);
    check("t2_ack", dbg_ack, 1);
    check("t2_mem3", rf_mem[3], 8'h11);
    step();
`else
    // T6: no starvation logic; pipe_we held 20 cycles, debug write waits
    pipe_we = 1'b1; pipe_w_addr = 4'd0; pipe_w_data = 8'h01;
    dbg_issue(1'b1, 4'd3, 8'h11);
    for (int i = 0; i < 20; i++) begin
      check("t6_no_stall", pipe_stall, 0);
      check("t6_no_ack", dbg_ack, 0);
      step();
    end
    pipe_we = 1'b0;
    wait_ack(n);
    check("t6_ack_latency", n, 1);
    check("t6_mem3", rf_mem[3], 8'h11);
    step();
`endif

    // T5: reset while the debug write waits
    pipe_we = 1'b1; pipe_w_addr = 4'd0;
    dbg_issue(1'b1, 4'd4, 8'hEE);
`ifdef KCPSMX_RF_STARVE_EN
    n = 0;
    while (!pipe_stall && n < 20) begin step(); n++; end
    check("t5_in_stall", pipe_stall, 1);
`else
    step();
`endif
    check("t5_busy", dbg_ready, 0);
    reset = 1'b0;
    #1;
    check("t5_async_stall", pipe_stall, 0);
    check("t5_async_ready", dbg_ready, 1);
    step();
    step();
    pipe_we = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_no_ack", dbg_ack, 0);
      check("t5_ready", dbg_ready, 1);
    end
    check("t5_mem4_untouched", rf_mem[4], 8'h00);

    // Randomized traffic; dbg_req toggles freely and must be ignored when not ready
    level = 0;
    for (int c = 0; c < 2500; c++) begin
      if (c % 200 == 0) level = $urandom_range(0, 4);
      if (pipe_stall) begin
        pipe_we    = ($urandom_range(0, 7) == 0);
        pipe_y_use = ($urandom_range(0, 7) == 0);
      end else begin
        pipe_we    = ($urandom_range(0, 3) < level);
        pipe_y_use = ($urandom_range(0, 3) < level);
      end
      pipe_w_addr = AW'($urandom);
      pipe_w_data = DW'($urandom);
      pipe_x_addr = AW'($urandom);
      pipe_y_addr = AW'($urandom);
      dbg_req     = ($urandom_range(0, 2) == 0);
      dbg_we      = ($urandom_range(0, 1) == 1);
      dbg_addr    = AW'($urandom);
      dbg_wdata   = DW'($urandom);
      reset       = ($urandom_range(0, 299) != 0);
      step();
    end
    reset = 1'b1; pipe_we = 1'b0; pipe_y_use = 1'b0; dbg_req = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 16; i++) check("final_mem", rf_mem[i], m_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
